// File: rtl/cpu_prog_loader_pkg.sv
// Shared types and default sizes for the CPU program loader.
package cpu_prog_loader_pkg;

    localparam int unsigned LD_AW        = 8;
    localparam int unsigned LD_DW        = 8;
    localparam int unsigned LD_MEM_DEPTH = 256;
    localparam int unsigned LD_CYC_W     = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_CHK,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } ld_state_e;

    typedef enum logic [1:0] {
        LD_ERR_NONE = 2'b00,
        LD_ERR_CHK  = 2'b01,
        LD_ERR_TMO  = 2'b10,
        LD_ERR_LEN  = 2'b11
    } ld_err_e;

endpackage

// File: rtl/cpu_prog_loader_if.sv
// Program byte stream (valid/ready) between the byte source and the loader.
interface cpu_prog_loader_if #(
    parameter int unsigned DW = 8
);
    logic          ivalid;
    logic [DW-1:0] idata;
    logic          oready;

    modport master (output ivalid, output idata, input oready);
    modport slave  (input ivalid, input idata, output oready);
endinterface

// File: rtl/cpu_prog_loader.sv
// Loads a program byte stream into CPU memory from address 0, runs the CPU and times the run.
// Build option CPU_LD_CHKSUM_EN adds a trailing checksum byte that must zero the byte sum.
module cpu_prog_loader
    import cpu_prog_loader_pkg::*;
#(
    parameter int unsigned AW        = LD_AW,
    parameter int unsigned DW        = LD_DW,
    parameter int unsigned MEM_DEPTH = LD_MEM_DEPTH,
    parameter int unsigned CYC_W     = LD_CYC_W
) (
    input  logic             iclk,
    input  logic             irst_n,
    input  logic             istart,
    input  logic [AW:0]      ilen,
    cpu_prog_loader_if.slave stream,
    output logic             omem_we,
    output logic [AW-1:0]    omem_addr,
    output logic [DW-1:0]    omem_wdata,
    output logic             ocpu_en,
    input  logic             icpu_done,
    output logic             obusy,
    output logic             oload_done,
    output logic [1:0]       oerr,
    output logic [CYC_W-1:0] ocycles
);

    localparam int unsigned      CW      = AW + 1;
    localparam logic [CYC_W-1:0] CYC_MAX = '1;

    ld_state_e   state, state_n;
    ld_err_e     err_q, err_d;
    logic [AW:0] len_q, cnt_q;
    logic        ready_d, busy_d, load_done_d, cpu_en_d;
    logic        xfer, start_acc, len_bad, last_xfer, cyc_max;

    assign xfer      = stream.ivalid && stream.oready;
    assign start_acc = istart && (state == ST_IDLE || state == ST_DONE || state == ST_ERR);
    assign len_bad   = (ilen == '0) || (32'(ilen) > MEM_DEPTH);
    // cnt_q is one bit wider than the address so a full-depth program ends without wrapping
    assign last_xfer = xfer && (state == ST_LOAD) && ((cnt_q + CW'(1)) == len_q);
    assign cyc_max   = (ocycles == CYC_MAX);
    assign oerr      = err_q;

`ifdef CPU_LD_CHKSUM_EN
    logic [DW-1:0] sum_q;
    logic          chk_ok;

    assign chk_ok = ((sum_q + stream.idata) == '0);

    // Running modulo-2^DW sum of the program bytes
    always_ff @(posedge iclk) begin
        if (!irst_n)                         sum_q <= '0;
        else if (start_acc)                  sum_q <= '0;
        else if (state == ST_LOAD && xfer)   sum_q <= sum_q + stream.idata;
    end
`endif

    always_ff @(posedge iclk) begin
        if (!irst_n) state <= ST_IDLE;
        else         state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start_acc) state_n = len_bad ? ST_ERR : ST_LOAD;
            end
            ST_LOAD: begin
`ifdef CPU_LD_CHKSUM_EN
                if (last_xfer) state_n = ST_CHK;
`else
                if (last_xfer) state_n = ST_RUN;
`endif
            end
`ifdef CPU_LD_CHKSUM_EN
            ST_CHK: begin
                if (xfer) state_n = chk_ok ? ST_RUN : ST_ERR;
            end
`endif
            ST_RUN: begin
                // first RUN cycle only raises ocpu_en; done wins over the timeout
                if (ocpu_en) begin
                    if (icpu_done)    state_n = ST_DONE;
                    else if (cyc_max) state_n = ST_ERR;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_comb begin
        ready_d     = (state_n == ST_LOAD) || (state_n == ST_CHK);
        busy_d      = ready_d || (state_n == ST_RUN);
        load_done_d = (state_n == ST_DONE);
        cpu_en_d    = (state == ST_RUN) && (state_n == ST_RUN);
        err_d       = err_q;
        if (start_acc)                                   err_d = len_bad ? LD_ERR_LEN : LD_ERR_NONE;
        else if (state == ST_RUN && state_n == ST_ERR)   err_d = LD_ERR_TMO;
        else if (state == ST_CHK && state_n == ST_ERR)   err_d = LD_ERR_CHK;
    end

    always_ff @(posedge iclk) begin
        if (!irst_n) begin
            stream.oready <= 1'b0;
            obusy         <= 1'b0;
            oload_done    <= 1'b0;
            ocpu_en       <= 1'b0;
            err_q         <= LD_ERR_NONE;
            omem_we       <= 1'b0;
            omem_addr     <= '0;
            omem_wdata    <= '0;
            ocycles       <= '0;
            len_q         <= '0;
            cnt_q         <= '0;
        end else begin
            stream.oready <= ready_d;
            obusy         <= busy_d;
            oload_done    <= load_done_d;
            ocpu_en       <= cpu_en_d;
            err_q         <= err_d;
            omem_we       <= 1'b0;
            if (start_acc && !len_bad) begin
                len_q   <= ilen;
                cnt_q   <= '0;
                ocycles <= '0;
            end else if (state == ST_LOAD && xfer) begin
                omem_we    <= 1'b1;
                omem_addr  <= cnt_q[AW-1:0];
                omem_wdata <= stream.idata;
                cnt_q      <= cnt_q + CW'(1);
            end
            if (ocpu_en && !cyc_max) ocycles <= ocycles + CYC_W'(1);
        end
    end

endmodule
